// File: rtl/fetch_queue.sv
// Instruction fetch stage with a small prefetch queue.
// Owns the fetch PC, issues 1-cycle imem reads, buffers {pc, instr}.
module fetch_queue #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         redirect,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic                         imem_req,
  output logic [PC_W-1:0]              imem_addr,
  input  logic [INS_W-1:0]             imem_rdata,
  output logic                         out_valid,
  output logic [PC_W-1:0]              out_pc,
  output logic [INS_W-1:0]             out_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PC_W-1:0]  r_fetch_pc;
  logic [PC_W-1:0]  r_pc_mem  [DEPTH];
  logic [INS_W-1:0] r_ins_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_inflight;
  logic [PC_W-1:0]  r_inflight_pc;

  logic [CW:0]      w_occ;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic [PC_W-1:0]  w_redir_pc;

  // The in-flight response already owns a slot, so issue never overflows.
  assign w_occ      = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue    = !reset && !redirect && (w_occ < (CW+1)'(DEPTH));
  assign w_push     = r_inflight && !redirect && !reset;
  assign w_pop      = out_valid && !stall && !redirect;
  assign w_redir_pc = redirect_pc & ~PC_W'(3);

  assign imem_req   = w_issue;
  assign imem_addr  = r_fetch_pc;
  assign out_valid  = (r_count != '0);
  assign out_pc     = r_pc_mem[r_head];
  assign out_instr  = r_ins_mem[r_head];
  assign count      = r_count;

  // Control state: fetch PC, pointers, occupancy and in-flight tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect) begin
      r_fetch_pc    <= w_redir_pc;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + PC_W'(4);
      end
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: the returning instruction lands at the tail.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]  <= r_inflight_pc;
      r_ins_mem[r_tail] <= imem_rdata;
    end
  end

endmodule
